// File: rtl/vproc_pkg.sv
// Shared vector-processor types: ELEM op encodings, element width, register
// group multiplier and the ELEM sequencer state, plus group sizing helpers.
package vproc_pkg;

    typedef enum logic [4:0] {
        ELEM_XMV       = 5'd0,
        ELEM_VPOPC     = 5'd1,
        ELEM_VFIRST    = 5'd2,
        ELEM_VID       = 5'd3,
        ELEM_VIOTA     = 5'd4,
        ELEM_VRGATHER  = 5'd5,
        ELEM_VCOMPRESS = 5'd6,
        ELEM_FLUSH     = 5'd7,
        ELEM_VREDSUM   = 5'd8,
        ELEM_VREDAND   = 5'd9,
        ELEM_VREDOR    = 5'd10,
        ELEM_VREDXOR   = 5'd11,
        ELEM_VREDMINU  = 5'd12,
        ELEM_VREDMIN   = 5'd13,
        ELEM_VREDMAXU  = 5'd14,
        ELEM_VREDMAX   = 5'd15
    } op_elem;

    typedef enum logic [1:0] {
        VSEW_8       = 2'd0,
        VSEW_16      = 2'd1,
        VSEW_32      = 2'd2,
        VSEW_INVALID = 2'd3
    } cfg_vsew;

    typedef enum logic [1:0] {
        EMUL_1 = 2'd0,
        EMUL_2 = 2'd1,
        EMUL_4 = 2'd2,
        EMUL_8 = 2'd3
    } cfg_emul;

    typedef enum logic [1:0] {
        ELEM_SEQ_IDLE  = 2'd0,
        ELEM_SEQ_RUN   = 2'd1,
        ELEM_SEQ_FLUSH = 2'd2
    } elem_seq_state_e;

    // Elements in a register group: bytes per group divided by bytes per element.
    function automatic int unsigned elem_group_cnt(cfg_vsew eew, cfg_emul emul,
                                                   int unsigned vreg_w);
        return ((vreg_w / 8) << emul) >> eew;
    endfunction

    // Flush beats cover the group at 32-bit granularity.
    function automatic int unsigned elem_flush_cnt(cfg_emul emul, int unsigned vreg_w);
        return (vreg_w / 32) << emul;
    endfunction

endpackage

// File: rtl/vproc_elem_seq.sv
// ELEM unit sequencer: expands one decoded instruction into per-beat control
// words on the ELEM pipe_in handshake, optionally followed by a flush phase
// that writes the remainder of the destination group with mask 0.
//
// state          | meaning
// ELEM_SEQ_IDLE  | no instruction held, instr_ready_o high
// ELEM_SEQ_RUN   | issuing element beats (gather: AUX_N sub-beats per element)
// ELEM_SEQ_FLUSH | issuing ELEM_FLUSH beats after vcompress / reductions
module vproc_elem_seq
    import vproc_pkg::*;
#(
    parameter int unsigned VREG_W         = 128,
    parameter int unsigned GATHER_OP_W    = 32,
    parameter int unsigned VL_W           = 12,
    parameter bit          DONT_CARE_ZERO = 1'b0,
    localparam int unsigned AUX_N = VREG_W / GATHER_OP_W,
    localparam int unsigned AUX_W = (AUX_N > 1) ? $clog2(AUX_N) : 1,
    localparam int unsigned IDX_W = $clog2(VREG_W) + 1
) (
    input  logic             clk_i,
    input  logic             async_rst_ni,
    input  logic             sync_rst_ni,

    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  op_elem           instr_op_i,
    input  cfg_vsew          instr_eew_i,
    input  cfg_emul          instr_emul_i,
    input  logic [VL_W-1:0]  instr_vl_i,
    input  logic             instr_masked_i,
    input  logic             instr_flush_i,
    input  logic [4:0]       instr_vaddr_i,

    output logic             out_valid_o,
    input  logic             out_ready_i,
    output op_elem           out_op_o,
    output cfg_vsew          out_eew_o,
    output cfg_emul          out_emul_o,
    output logic             out_masked_o,
    output logic [4:0]       out_vaddr_o,
    output logic             out_first_cycle_o,
    output logic             out_last_cycle_o,
    output logic             out_vl_part_0_o,
    output logic             out_vl_0_o,
    output logic [AUX_W-1:0] out_aux_count_o,
    output logic [IDX_W-1:0] out_elem_idx_o,

    output logic             done_o,
    output logic             busy_o
);

    localparam logic [AUX_W-1:0] AUX_LAST = AUX_W'(AUX_N - 1);
    localparam logic             DC_BIT   = DONT_CARE_ZERO ? 1'b0 : 1'bx;

    elem_seq_state_e  state_q, state_d;
    logic [IDX_W-1:0] elem_idx_q, elem_idx_d;
    logic [AUX_W-1:0] aux_q, aux_d;
    logic [IDX_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [IDX_W-1:0] elem_last_q, elem_last_d;
    logic [IDX_W-1:0] flush_last_q, flush_last_d;
    logic             gather_q, gather_d;
    logic             flush_en_q, flush_en_d;
    logic             done_q, done_d;

    op_elem           op_q, op_d;
    cfg_vsew          eew_q, eew_d;
    cfg_emul          emul_q, emul_d;
    logic [VL_W-1:0]  vl_q, vl_d;
    logic             masked_q, masked_d;
    logic [4:0]       vaddr_q, vaddr_d;

    logic op_ok, instr_ok, flushable, single_beat;
    logic beat_fire, last_run, dc;

    // Unknown ops, a flush op issued as an instruction, or an invalid width
    // collapse to a single beat so the sequencer can never hang.
    assign op_ok       = (instr_op_i <= ELEM_VREDMAX) && (instr_op_i != ELEM_FLUSH);
    assign instr_ok    = op_ok && (instr_eew_i != VSEW_INVALID);
    assign flushable   = (instr_op_i == ELEM_VCOMPRESS) ||
                         ((instr_op_i >= ELEM_VREDSUM) && (instr_op_i <= ELEM_VREDMAX));
    assign single_beat = !instr_ok || (instr_op_i == ELEM_XMV);

    assign beat_fire = out_valid_o && out_ready_i;
    assign last_run  = (state_q == ELEM_SEQ_RUN) && (elem_idx_q == elem_last_q) &&
                       (!gather_q || (aux_q == AUX_LAST));

    // Next-state, counter advance and instruction capture.
    always_comb begin
        state_d      = state_q;
        elem_idx_d   = elem_idx_q;
        aux_d        = aux_q;
        flush_cnt_d  = flush_cnt_q;
        elem_last_d  = elem_last_q;
        flush_last_d = flush_last_q;
        gather_d     = gather_q;
        flush_en_d   = flush_en_q;
        op_d         = op_q;
        eew_d        = eew_q;
        emul_d       = emul_q;
        vl_d         = vl_q;
        masked_d     = masked_q;
        vaddr_d      = vaddr_q;
        done_d       = 1'b0;
        case (state_q)
            ELEM_SEQ_IDLE: begin
                if (instr_valid_i) begin
                    state_d      = ELEM_SEQ_RUN;
                    elem_idx_d   = '0;
                    aux_d        = '0;
                    flush_cnt_d  = '0;
                    op_d         = instr_op_i;
                    eew_d        = instr_eew_i;
                    emul_d       = instr_emul_i;
                    vl_d         = instr_vl_i;
                    masked_d     = instr_masked_i;
                    vaddr_d      = instr_vaddr_i;
                    gather_d     = instr_ok && (instr_op_i == ELEM_VRGATHER);
                    flush_en_d   = instr_ok && instr_flush_i && flushable;
                    elem_last_d  = single_beat ? '0 :
                        IDX_W'(elem_group_cnt(instr_eew_i, instr_emul_i, VREG_W) - 32'd1);
                    flush_last_d = IDX_W'(elem_flush_cnt(instr_emul_i, VREG_W) - 32'd1);
                end
            end
            ELEM_SEQ_RUN: begin
                if (beat_fire) begin
                    if (last_run) begin
                        if (flush_en_q) begin
                            state_d     = ELEM_SEQ_FLUSH;
                            flush_cnt_d = '0;
                        end else begin
                            state_d = ELEM_SEQ_IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (gather_q && (aux_q != AUX_LAST)) begin
                        aux_d = aux_q + AUX_W'(1);
                    end else begin
                        aux_d      = '0;
                        elem_idx_d = elem_idx_q + IDX_W'(1);
                    end
                end
            end
            ELEM_SEQ_FLUSH: begin
                if (beat_fire) begin
                    if (flush_cnt_q == flush_last_q) begin
                        state_d = ELEM_SEQ_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        flush_cnt_d = flush_cnt_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ELEM_SEQ_IDLE;
        endcase
    end

    // State, counters and latched fields; either reset drops the instruction.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q      <= ELEM_SEQ_IDLE;
            elem_idx_q   <= '0;
            aux_q        <= '0;
            flush_cnt_q  <= '0;
            elem_last_q  <= '0;
            flush_last_q <= '0;
            gather_q     <= 1'b0;
            flush_en_q   <= 1'b0;
            done_q       <= 1'b0;
            op_q         <= ELEM_XMV;
            eew_q        <= VSEW_8;
            emul_q       <= EMUL_1;
            vl_q         <= '0;
            masked_q     <= 1'b0;
            vaddr_q      <= '0;
        end else if (!sync_rst_ni) begin
            state_q      <= ELEM_SEQ_IDLE;
            elem_idx_q   <= '0;
            aux_q        <= '0;
            flush_cnt_q  <= '0;
            elem_last_q  <= '0;
            flush_last_q <= '0;
            gather_q     <= 1'b0;
            flush_en_q   <= 1'b0;
            done_q       <= 1'b0;
            op_q         <= ELEM_XMV;
            eew_q        <= VSEW_8;
            emul_q       <= EMUL_1;
            vl_q         <= '0;
            masked_q     <= 1'b0;
            vaddr_q      <= '0;
        end else begin
            state_q      <= state_d;
            elem_idx_q   <= elem_idx_d;
            aux_q        <= aux_d;
            flush_cnt_q  <= flush_cnt_d;
            elem_last_q  <= elem_last_d;
            flush_last_q <= flush_last_d;
            gather_q     <= gather_d;
            flush_en_q   <= flush_en_d;
            done_q       <= done_d;
            op_q         <= op_d;
            eew_q        <= eew_d;
            emul_q       <= emul_d;
            vl_q         <= vl_d;
            masked_q     <= masked_d;
            vaddr_q      <= vaddr_d;
        end
    end

    // Beat fields are meaningless while idle; flags stay low there.
    assign dc = (state_q == ELEM_SEQ_IDLE);

    assign instr_ready_o = (state_q == ELEM_SEQ_IDLE);
    assign out_valid_o   = (state_q != ELEM_SEQ_IDLE);
    assign busy_o        = (state_q != ELEM_SEQ_IDLE);
    assign done_o        = done_q;

    assign out_op_o     = dc ? op_elem'({$bits(op_elem){DC_BIT}}) :
                          ((state_q == ELEM_SEQ_FLUSH) ? ELEM_FLUSH : op_q);
    assign out_eew_o    = dc ? cfg_vsew'({$bits(cfg_vsew){DC_BIT}}) : eew_q;
    assign out_emul_o   = dc ? cfg_emul'({$bits(cfg_emul){DC_BIT}}) : emul_q;
    assign out_masked_o = dc ? DC_BIT : masked_q;
    assign out_vaddr_o  = dc ? {5{DC_BIT}} : vaddr_q;

    assign out_first_cycle_o = (state_q == ELEM_SEQ_RUN) && (elem_idx_q == '0) && (aux_q == '0);
    assign out_last_cycle_o  = last_run;
    assign out_vl_part_0_o   = (state_q == ELEM_SEQ_FLUSH) ||
                               ((state_q == ELEM_SEQ_RUN) && (32'(elem_idx_q) >= 32'(vl_q)));
    assign out_vl_0_o        = !dc && (vl_q == '0);
    assign out_aux_count_o   = dc ? {AUX_W{DC_BIT}} : aux_q;
    assign out_elem_idx_o    = dc ? {IDX_W{DC_BIT}} :
                               ((state_q == ELEM_SEQ_FLUSH) ? flush_cnt_q : elem_idx_q);

endmodule

// File: tb/tb_vproc_elem_seq.sv
// Scoreboard bench for vproc_elem_seq: each issued instruction is expanded by
// a plain loop-based model into its expected beat list; a monitor compares
// every presented beat (including stalled ones) against the queue head.
module tb_vproc_elem_seq;
    import vproc_pkg::*;

    localparam int VREG_W = 128;
    localparam int GOP_W  = 32;
    localparam int AUX_N  = VREG_W / GOP_W;
    localparam int VL_W   = 12;

    typedef struct packed {
        logic [4:0] op;
        logic [1:0] eew;
        logic [1:0] emul;
        logic       masked;
        logic [4:0] vaddr;
        logic       first;
        logic       last;
        logic       vp0;
        logic       v0;
        logic [1:0] aux;
        logic [7:0] idx;
    } beat_t;

    logic            clk = 1'b0;
    logic            async_rst_ni = 1'b0;
    logic            sync_rst_ni = 1'b1;
    logic            instr_valid = 1'b0;
    logic            instr_ready;
    op_elem          instr_op = ELEM_XMV;
    cfg_vsew         instr_eew = VSEW_8;
    cfg_emul         instr_emul = EMUL_1;
    logic [VL_W-1:0] instr_vl = '0;
    logic            instr_masked = 1'b0;
    logic            instr_flush = 1'b0;
    logic [4:0]      instr_vaddr = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    op_elem          out_op;
    cfg_vsew         out_eew;
    cfg_emul         out_emul;
    logic            out_masked;
    logic [4:0]      out_vaddr;
    logic            out_first, out_last, out_vp0, out_v0;
    logic [1:0]      out_aux;
    logic [7:0]      out_idx;
    logic            done, busy;

    int    errors = 0;
    int    checks = 0;
    int    exp_done = 0;
    int    rdy_mode = 0;
    beat_t exp_q[$];

    vproc_elem_seq #(
        .VREG_W(VREG_W), .GATHER_OP_W(GOP_W), .VL_W(VL_W), .DONT_CARE_ZERO(1'b1)
    ) dut (
        .clk_i(clk), .async_rst_ni(async_rst_ni), .sync_rst_ni(sync_rst_ni),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_op_i(instr_op), .instr_eew_i(instr_eew), .instr_emul_i(instr_emul),
        .instr_vl_i(instr_vl), .instr_masked_i(instr_masked), .instr_flush_i(instr_flush),
        .instr_vaddr_i(instr_vaddr),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_op_o(out_op),
        .out_eew_o(out_eew), .out_emul_o(out_emul), .out_masked_o(out_masked),
        .out_vaddr_o(out_vaddr), .out_first_cycle_o(out_first), .out_last_cycle_o(out_last),
        .out_vl_part_0_o(out_vp0), .out_vl_0_o(out_v0), .out_aux_count_o(out_aux),
        .out_elem_idx_o(out_idx), .done_o(done), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference expansion: element loop (with gather sub-beats) then flush loop.
    task automatic exp_push(int op, int eew, int emul, int vl, bit masked, bit flush, int vaddr);
        bit    valid_op = (op <= 15) && (op != 7) && (eew != 3);
        int    n = (VREG_W / 8 << emul) >> eew;
        int    subs = (valid_op && op == 5) ? AUX_N : 1;
        int    elems = (!valid_op || op == 0) ? 1 : n;
        int    total = elems * subs;
        beat_t b;
        for (int k = 0; k < total; k++) begin
            b = '0;
            b.op = 5'(op); b.eew = 2'(eew); b.emul = 2'(emul);
            b.masked = masked; b.vaddr = 5'(vaddr);
            b.idx = 8'(k / subs); b.aux = 2'(k % subs);
            b.first = (k == 0); b.last = (k == total - 1);
            b.vp0 = (k / subs) >= vl; b.v0 = (vl == 0);
            exp_q.push_back(b);
        end
        if (valid_op && flush && (op == 6 || op >= 8)) begin
            for (int f = 0; f < ((VREG_W / 32) << emul); f++) begin
                b = '0;
                b.op = 5'd7; b.eew = 2'(eew); b.emul = 2'(emul);
                b.masked = masked; b.vaddr = 5'(vaddr);
                b.idx = 8'(f); b.vp0 = 1'b1; b.v0 = (vl == 0);
                exp_q.push_back(b);
            end
        end
        exp_done++;
    endtask

    // Monitor: every presented beat must match the queue head; pop on handshake.
    initial begin
        beat_t act;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                act = {5'(out_op), 2'(out_eew), 2'(out_emul), out_masked, out_vaddr,
                       out_first, out_last, out_vp0, out_v0, out_aux, out_idx};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got %0h with no beat expected", act);
                end else begin
                    if (act !== exp_q[0]) begin
                        errors++;
                        $display("FAIL beat: got %0h expected %0h", act, exp_q[0]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                checks++;
                if (exp_done == 0 || exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL done: pulse with %0d beats left, %0d dones pending",
                             exp_q.size(), exp_done);
                end else begin
                    exp_done--;
                end
                check("ready_after_done", 32'(instr_ready), 32'd1);
                check("busy_after_done", 32'(busy), 32'd0);
            end
        end
    end

    // Ready driver: always high, or a coin toss every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1 out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic issue(int op, int eew, int emul, int vl, bit masked, bit flush, int vaddr);
        int g = 0;
        @(negedge clk);
        while (!instr_ready && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) begin
            errors++;
            $display("FAIL issue_timeout: ready=%0d required 1", instr_ready);
        end
        instr_valid = 1'b1;
        instr_op = op_elem'(5'(op)); instr_eew = cfg_vsew'(2'(eew));
        instr_emul = cfg_emul'(2'(emul)); instr_vl = VL_W'(vl);
        instr_masked = masked; instr_flush = flush; instr_vaddr = 5'(vaddr);
        exp_push(op, eew, emul, vl, masked, flush, vaddr);
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic wait_all(string name);
        int g = 0;
        while ((exp_done != 0 || exp_q.size() != 0) && g < 20000) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (g >= 20000) begin
            errors++;
            $display("FAIL %s_timeout: beats left %0d dones left %0d required 0",
                     name, exp_q.size(), exp_done);
            exp_q.delete();
            exp_done = 0;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        async_rst_ni = 1'b1;

        issue(3, 2, 0, 3, 1'b0, 1'b0, 4);              // VID e32 m1 vl3
        wait_all("vid");
        issue(0, 0, 0, 5, 1'b1, 1'b0, 9);              // XMV e8
        wait_all("xmv");
        issue(5, 2, 0, 4, 1'b0, 1'b0, 2);              // VRGATHER e32 m1 vl4
        wait_all("gather");
        issue(8, 2, 1, 0, 1'b0, 1'b1, 6);              // VREDSUM e32 m2 vl0 flush
        wait_all("redsum");
        rdy_mode = 1;
        issue(6, 1, 0, 5, 1'b1, 1'b1, 12);             // VCOMPRESS e16 flush, stalls
        wait_all("compress");
        rdy_mode = 0;

        // Async reset in the middle of a VIOTA.
        issue(4, 0, 0, 10, 1'b0, 1'b0, 3);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 async_rst_ni = 1'b0;
        exp_q.delete();
        exp_done = 0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        async_rst_ni = 1'b1;
        repeat (6) @(negedge clk);
        check("arst_ready", 32'(instr_ready), 32'd1);
        issue(0, 1, 2, 1, 1'b0, 1'b0, 17);
        wait_all("xmv_after_arst");

        // Synchronous reset in the middle of a VID.
        issue(3, 0, 1, 20, 1'b0, 1'b0, 8);
        repeat (4) @(negedge clk);
        sync_rst_ni = 1'b0;
        @(posedge clk);
        exp_q.delete();
        exp_done = 0;
        #1 sync_rst_ni = 1'b1;
        check("srst_valid", 32'(out_valid), 32'd0);
        check("srst_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);

        // Random instructions, including unsupported op and width encodings.
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 17), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 140), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 31));
            wait_all("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vproc_elem_seq.md
Name: vproc_elem_seq

Overview:
- Sequencer in front of the ELEM unit pipeline. Accepts one decoded ELEM instruction at a time and expands it into a stream of per-beat control words: op, eew, first/last flags, vl_part_0, vl_0, aux_count, element index.
- Drives the ELEM pipe_in handshake.
- Appends a flush phase after vcompress and reductions, so the rest of the destination register group is written with mask 0.

Parameters:
- VREG_W, 128, vector register width in bits (power of 2, >= 64).
- GATHER_OP_W, 32, gather operand width in bits; AUX_N = VREG_W/GATHER_OP_W beats per gathered element (power of 2, >= 1).
- VL_W, 12, width of the vl field; must satisfy 2^VL_W > 8*VREG_W/8.
- DONT_CARE_ZERO, 0, drive don't-care output fields to 0 instead of x.

Ports:
- clk_i  in  1  clock
- async_rst_ni  in  1  asynchronous active-low reset
- sync_rst_ni  in  1  synchronous active-low reset (same effect as async)
- instr_valid_i  in  1  instruction offered
- instr_ready_o  out  1  sequencer idle, accepts instruction
- instr_op_i  in  op_elem width  ELEM op (vproc_pkg enum)
- instr_eew_i  in  vsew width  element width VSEW_8/16/32
- instr_emul_i  in  emul width  EMUL_1/2/4/8
- instr_vl_i  in  VL_W  vector length in elements
- instr_masked_i  in  1  v0-masked
- instr_flush_i  in  1  append flush phase (only honoured for VCOMPRESS and VRED*)
- instr_vaddr_i  in  5  destination vreg/xreg address
- out_valid_o  out  1  control beat valid (to ELEM pipe_in_valid_i)
- out_ready_i  in  1  ELEM ready
- out_op_o  out  op_elem width  beat op (ELEM_FLUSH during flush phase)
- out_eew_o / out_emul_o / out_masked_o / out_vaddr_o  out  as input  latched instruction fields
- out_first_cycle_o  out  1  first beat of instruction
- out_last_cycle_o  out  1  last beat of instruction
- out_vl_part_0_o  out  1  element index >= vl
- out_vl_0_o  out  1  vl == 0
- out_aux_count_o  out  clog2(AUX_N) (min 1)  gather sub-beat index
- out_elem_idx_o  out  clog2(VREG_W)+1  current element index
- done_o  out  1  one-cycle pulse on handshake of final beat
- busy_o  out  1  state != IDLE

Behaviour:
- States: IDLE, RUN, FLUSH.
- Reset (either reset): state = IDLE, all counters 0. Outputs: out_valid_o = 0, done_o = 0, busy_o = 0, instr_ready_o = 1.
- instr_ready_o = (state == IDLE). On instr_valid_i & instr_ready_o:
  - latch all fields, elem_idx = 0, aux = 0, flush_cnt = 0;
  - state -> RUN on the next cycle; out_valid_o rises that cycle.
  - Zero-bubble back-to-back acceptance is not required.
- Group element count N = (VREG_W/8 << log2(emul)) >> log2(eew bytes). Example: VREG_W=128, EEW=8, EMUL_2 gives N = 32.
- RUN beat set:
  - XMV: exactly one beat, elem_idx = 0.
  - VRGATHER: N*AUX_N beats; aux increments fastest and wraps AUX_N-1 -> 0 with elem_idx+1.
  - All other ops: N beats, aux = 0.
- Beat flags:
  - first_cycle = 1 only on the first RUN beat.
  - last_cycle = 1 only on the final RUN beat.
  - vl_part_0 = (elem_idx >= vl).
  - vl_0 = (vl == 0), constant per instruction.
  - vl = 0 still produces the full beat set.
- Advance only on out_valid_o & out_ready_i. While out_ready_i = 0, every output holds stable.
- End of RUN (final RUN beat handshake):
  - If flush enabled and op in {VCOMPRESS, VREDSUM..VREDMAX}: state -> FLUSH.
  - Otherwise: state -> IDLE and done_o pulses.
- FLUSH: F = (VREG_W/32) << log2(emul) beats.
  - out_op_o = ELEM_FLUSH; first_cycle = 0; last_cycle = 0; vl_part_0 = 1; elem_idx = flush_cnt.
  - On the handshake of beat F-1: state -> IDLE, done_o pulses.
- done_o is registered and asserted the cycle after the final handshake.
- Unsupported op/eew/emul encodings: treated as XMV-length (one beat), then IDLE. No hang.
- Reset mid-operation: instruction dropped, no done_o, out_valid_o low the next cycle.
- Counters never wrap within an instruction. Width clog2(VREG_W)+1 covers N ≤ VREG_W (EEW8, EMUL8).

Decomposition:
- vproc_pkg: add elem_seq_state_e {ELEM_SEQ_IDLE, ELEM_SEQ_RUN, ELEM_SEQ_FLUSH}.
- Reuse the existing op_elem, vsew and emul enums.
- Add function elem_group_cnt(eew, emul, VREG_W) to the package; no sub-module needed.

Test Plan:
- VREG_W=128, VID, EEW32, EMUL_1, vl=3, out_ready_i=1 -> 4 beats, elem_idx 0..3; vl_part_0 = 0,0,0,1; first on beat 0, last on beat 3; done_o pulses once.
- XMV, EEW8 -> exactly 1 beat with first = last = 1; instr_ready_o high again 1 cycle after the handshake.
- VRGATHER, EEW32, EMUL_1, vl=4, GATHER_OP_W=32 -> 16 beats; aux sequence 0,1,2,3 repeating; elem_idx increments every 4th beat; last_cycle on beat 15.
- VREDSUM, EEW32, EMUL_2, vl=0, flush=1 -> 8 RUN beats with vl_0 = 1, then 8 ELEM_FLUSH beats (elem_idx 0..7), then done_o.
- VCOMPRESS, EEW16, out_ready_i toggled 1-0-0-1 randomly -> beat fields stable while stalled; beat count 8 RUN + 4 FLUSH; no duplicate or skipped index.
- async_rst_ni pulsed during the RUN of VIOTA -> out_valid_o = 0, busy_o = 0, no done_o; a following XMV executes normally.
